// File: rtl/door_motor_sequencer.sv
// Door motor sequencer: dead-time-guarded open/close motor control with travel timeout and latched fault.
// Optional auto-close from OPEN_HOLD is enabled by defining DOOR_SEQ_AUTOCLOSE_EN.
module door_motor_sequencer #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned DEAD_CYCLES = 4,
  parameter int unsigned TRAVEL_MAX  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       open_req,
  input  logic       close_req,
  input  logic       obstruct,
  input  logic       lim_open,
  input  logic       lim_closed,
  output logic       motor_open,
  output logic       motor_close,
  output logic [2:0] state,
  output logic       fault
);

  localparam int unsigned CW = 8;

  // Counters run 0..LAST inside a state, so each phase lasts exactly N cycles.
  localparam logic [CW-1:0] DEAD_LAST   = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_MAX - 1);

  if (HOLD_CYCLES == 0 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1..255");
  end
  if (DEAD_CYCLES == 0 || DEAD_CYCLES > 255) begin : g_bad_dead
    $error("DEAD_CYCLES must be in 1..255");
  end
  if (TRAVEL_MAX == 0 || TRAVEL_MAX > 255) begin : g_bad_travel
    $error("TRAVEL_MAX must be in 1..255");
  end

  typedef enum logic [2:0] {
    ST_CLOSED    = 3'd0,
    ST_PRE_OPEN  = 3'd1,
    ST_OPENING   = 3'd2,
    ST_OPEN_HOLD = 3'd3,
    ST_PRE_CLOSE = 3'd4,
    ST_CLOSING   = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  state_t        cur_state;
  state_t        nxt_state;
  logic [CW-1:0] dead_cnt;
  logic [CW-1:0] dead_nxt;
  logic [CW-1:0] travel_cnt;
  logic [CW-1:0] travel_nxt;
  logic          open_cmd;

`ifdef DOOR_SEQ_AUTOCLOSE_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] hold_nxt;
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  assign open_cmd = obstruct | open_req;
  assign state    = cur_state;

  // Next-state and counter update; fault conditions first, then obstruct/open, close, timers.
  always_comb begin
    nxt_state  = cur_state;
    dead_nxt   = dead_cnt;
    travel_nxt = travel_cnt;
`ifdef DOOR_SEQ_AUTOCLOSE_EN
    hold_nxt   = hold_cnt;
`endif

    if (lim_open && lim_closed) begin
      nxt_state = ST_FAULT;
    end else begin
      case (cur_state)
        ST_CLOSED: begin
          if (open_cmd)         nxt_state = ST_PRE_OPEN;
          else if (!lim_closed) nxt_state = ST_PRE_CLOSE;
        end
        ST_PRE_OPEN: begin
          if (dead_cnt >= DEAD_LAST) nxt_state = ST_OPENING;
        end
        ST_PRE_CLOSE: begin
          if (open_cmd)                   nxt_state = ST_PRE_OPEN;
          else if (dead_cnt >= DEAD_LAST) nxt_state = ST_CLOSING;
        end
        ST_OPENING: begin
          if (lim_open)                        nxt_state = ST_OPEN_HOLD;
          else if (travel_cnt >= TRAVEL_LAST)  nxt_state = ST_FAULT;
        end
        ST_OPEN_HOLD: begin
          if (open_cmd)        nxt_state = ST_OPEN_HOLD;
          else if (close_req)  nxt_state = ST_PRE_CLOSE;
`ifdef DOOR_SEQ_AUTOCLOSE_EN
          else if (hold_cnt >= HOLD_LAST) nxt_state = ST_PRE_CLOSE;
`endif
        end
        ST_CLOSING: begin
          if (open_cmd)                        nxt_state = ST_PRE_OPEN;
          else if (lim_closed)                 nxt_state = ST_CLOSED;
          else if (travel_cnt >= TRAVEL_LAST)  nxt_state = ST_FAULT;
        end
        ST_FAULT: nxt_state = ST_FAULT;
        default:  nxt_state = ST_FAULT;
      endcase
    end

    // Every state change restarts all counters; otherwise only the active one advances.
    if (nxt_state != cur_state) begin
      dead_nxt   = '0;
      travel_nxt = '0;
`ifdef DOOR_SEQ_AUTOCLOSE_EN
      hold_nxt   = '0;
`endif
    end else begin
      case (cur_state)
        ST_PRE_OPEN, ST_PRE_CLOSE: dead_nxt   = sat_inc(dead_cnt);
        ST_OPENING, ST_CLOSING:    travel_nxt = sat_inc(travel_cnt);
`ifdef DOOR_SEQ_AUTOCLOSE_EN
        ST_OPEN_HOLD:              hold_nxt   = open_cmd ? '0 : sat_inc(hold_cnt);
`endif
        default: ;
      endcase
    end
  end

  // State, counters and outputs registered together so outputs always track the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= ST_CLOSED;
      dead_cnt    <= '0;
      travel_cnt  <= '0;
      motor_open  <= 1'b0;
      motor_close <= 1'b0;
      fault       <= 1'b0;
`ifdef DOOR_SEQ_AUTOCLOSE_EN
      hold_cnt    <= '0;
`endif
    end else begin
      cur_state   <= nxt_state;
      dead_cnt    <= dead_nxt;
      travel_cnt  <= travel_nxt;
      motor_open  <= (nxt_state == ST_OPENING);
      motor_close <= (nxt_state == ST_CLOSING);
      fault       <= (nxt_state == ST_FAULT);
`ifdef DOOR_SEQ_AUTOCLOSE_EN
      hold_cnt    <= hold_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_door_motor_sequencer.sv
// Scoreboard bench for door_motor_sequencer; expectations follow the build's DOOR_SEQ_AUTOCLOSE_EN setting.
module tb_door_motor_sequencer;

  localparam logic [2:0] S_CL = 3'd0;
  localparam logic [2:0] S_PO = 3'd1;
  localparam logic [2:0] S_OP = 3'd2;
  localparam logic [2:0] S_HO = 3'd3;
  localparam logic [2:0] S_PC = 3'd4;
  localparam logic [2:0] S_CG = 3'd5;
  localparam logic [2:0] S_FA = 3'd6;

  typedef struct packed {
    logic       rst;
    logic       op;
    logic       cl;
    logic       ob;
    logic       lo;
    logic       lc;
    logic [2:0] es;
  } stim_t;

  logic       clk;
  logic       rst;
  logic       open_req;
  logic       close_req;
  logic       obstruct;
  logic       lim_open;
  logic       lim_closed;
  logic       motor_open;
  logic       motor_close;
  logic [2:0] state;
  logic       fault;

  stim_t      plan[$];
  logic [5:0] sb[$];
  logic [5:0] got_v;
  logic [5:0] exp_v;
  int         n_checks;
  int         n_fail;
  int         step;

  door_motor_sequencer #(
    .HOLD_CYCLES(16),
    .DEAD_CYCLES(4),
    .TRAVEL_MAX (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .open_req   (open_req),
    .close_req  (close_req),
    .obstruct   (obstruct),
    .lim_open   (lim_open),
    .lim_closed (lim_closed),
    .motor_open (motor_open),
    .motor_close(motor_close),
    .state      (state),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs are a pure function of the expected state code.
  function automatic logic [5:0] expect_of(input logic [2:0] s);
    return {s, (s == S_OP), (s == S_CG), (s == S_FA)};
  endfunction

  task automatic add(input int n, input logic r, input logic op, input logic cl, input logic ob,
                     input logic lo, input logic lc, input logic [2:0] es);
    stim_t s;
    s = '{rst: r, op: op, cl: cl, ob: ob, lo: lo, lc: lc, es: es};
    repeat (n) plan.push_back(s);
  endtask

  // Drive one planned cycle, record its expectation, and advance past the sampling edge.
  task automatic drive_step();
    stim_t s;
    s = plan.pop_front();
    rst        = s.rst;
    open_req   = s.op;
    close_req  = s.cl;
    obstruct   = s.ob;
    lim_open   = s.lo;
    lim_closed = s.lc;
    sb.push_back(expect_of(s.es));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    add(2, 1, 1, 1, 1, 1, 1, S_CL);
    add(3, 0, 0, 0, 0, 0, 1, S_CL);
    step = 0;
    while (plan.size() != 0) begin
      drive_step();
      exp_v = sb.pop_front();
      got_v = {state, motor_open, motor_close, fault};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL test_reset step %0d: {state,mo,mc,fault} observed %b required %b", step, got_v, exp_v);
      end
      step++;
    end
  endtask

  task automatic test_open_cycle();
    add(1, 0, 1, 0, 0, 0, 1, S_PO);
    add(3, 0, 0, 0, 0, 0, 0, S_PO);
    add(6, 0, 0, 0, 0, 0, 0, S_OP);
    add(1, 0, 0, 0, 0, 1, 0, S_HO);
`ifdef DOOR_SEQ_AUTOCLOSE_EN
    add(15, 0, 0, 0, 0, 1, 0, S_HO);
    add(1, 0, 0, 0, 0, 1, 0, S_PC);
`else
    add(300, 0, 0, 0, 0, 1, 0, S_HO);
    add(1, 0, 0, 1, 0, 1, 0, S_PC);
`endif
    add(3, 0, 0, 0, 0, 0, 0, S_PC);
    add(1, 0, 0, 0, 0, 0, 0, S_CG);
    add(4, 0, 0, 0, 0, 0, 0, S_CG);
    add(1, 0, 0, 0, 0, 0, 1, S_CL);
    add(2, 0, 0, 0, 0, 0, 1, S_CL);
    step = 0;
    while (plan.size() != 0) begin
      drive_step();
      exp_v = sb.pop_front();
      got_v = {state, motor_open, motor_close, fault};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL test_open_cycle step %0d: {state,mo,mc,fault} observed %b required %b", step, got_v, exp_v);
      end
      step++;
    end
  endtask

  task automatic test_hold_controls();
    add(1, 0, 1, 0, 0, 0, 1, S_PO);
    add(3, 0, 0, 0, 0, 0, 0, S_PO);
    add(1, 0, 0, 0, 0, 0, 0, S_OP);
    add(1, 0, 0, 0, 0, 1, 0, S_HO);
    add(1, 0, 0, 1, 1, 1, 0, S_HO);  // close with obstruction is refused
    add(1, 0, 1, 1, 0, 1, 0, S_HO);  // open_req outranks close_req
`ifdef DOOR_SEQ_AUTOCLOSE_EN
    add(15, 0, 0, 0, 0, 1, 0, S_HO);
    add(1, 0, 0, 0, 0, 1, 0, S_PC);
`else
    add(1, 0, 0, 1, 0, 1, 0, S_PC);
`endif
    add(1, 0, 0, 0, 0, 0, 0, S_PC);
    add(1, 0, 1, 0, 0, 0, 0, S_PO);  // dead time restarts on reversal
    add(3, 0, 0, 0, 0, 0, 0, S_PO);
    add(1, 0, 0, 0, 0, 0, 0, S_OP);
    add(1, 0, 0, 0, 0, 1, 0, S_HO);
    add(1, 0, 0, 1, 0, 1, 0, S_PC);
    add(3, 0, 0, 0, 0, 0, 0, S_PC);
    add(1, 0, 0, 0, 0, 0, 0, S_CG);
    add(2, 0, 0, 0, 0, 0, 1, S_CL);
    step = 0;
    while (plan.size() != 0) begin
      drive_step();
      exp_v = sb.pop_front();
      got_v = {state, motor_open, motor_close, fault};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL test_hold_controls step %0d: {state,mo,mc,fault} observed %b required %b", step, got_v, exp_v);
      end
      step++;
    end
  endtask

  task automatic test_reversal();
    add(1, 0, 0, 0, 0, 0, 0, S_PC);
    add(3, 0, 0, 0, 0, 0, 0, S_PC);
    add(3, 0, 0, 0, 0, 0, 0, S_CG);
    add(1, 0, 0, 0, 1, 0, 0, S_PO);
    add(3, 0, 0, 0, 0, 0, 0, S_PO);
    add(3, 0, 0, 0, 0, 0, 0, S_OP);
    add(1, 0, 0, 0, 0, 1, 0, S_HO);
    add(1, 0, 0, 1, 0, 1, 0, S_PC);
    add(3, 0, 0, 0, 0, 0, 0, S_PC);
    add(2, 0, 0, 0, 0, 0, 0, S_CG);
    add(1, 0, 1, 0, 0, 0, 0, S_PO);  // open_req also reverses a closing door
    add(3, 0, 0, 0, 0, 0, 0, S_PO);
    add(1, 0, 0, 0, 0, 0, 0, S_OP);
    add(1, 0, 0, 0, 0, 1, 0, S_HO);
    add(1, 0, 0, 1, 0, 1, 0, S_PC);
    add(3, 0, 0, 0, 0, 0, 0, S_PC);
    add(1, 0, 0, 0, 0, 0, 0, S_CG);
    add(2, 0, 0, 0, 0, 0, 1, S_CL);
    step = 0;
    while (plan.size() != 0) begin
      drive_step();
      exp_v = sb.pop_front();
      got_v = {state, motor_open, motor_close, fault};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL test_reversal step %0d: {state,mo,mc,fault} observed %b required %b", step, got_v, exp_v);
      end
      step++;
    end
  endtask

  task automatic test_travel_fault();
    add(1, 0, 1, 0, 0, 0, 1, S_PO);
    add(3, 0, 0, 0, 0, 0, 0, S_PO);
    add(64, 0, 0, 0, 0, 0, 0, S_OP);
    add(1, 0, 0, 0, 0, 0, 0, S_FA);
    add(3, 0, 1, 0, 1, 0, 0, S_FA);
    add(2, 0, 0, 1, 0, 0, 1, S_FA);
    add(1, 1, 1, 0, 0, 0, 1, S_CL);
    add(2, 0, 0, 0, 0, 0, 1, S_CL);
    step = 0;
    while (plan.size() != 0) begin
      drive_step();
      exp_v = sb.pop_front();
      got_v = {state, motor_open, motor_close, fault};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL test_travel_fault step %0d: {state,mo,mc,fault} observed %b required %b", step, got_v, exp_v);
      end
      step++;
    end
  endtask

  task automatic test_limits_and_reset();
    add(1, 0, 0, 0, 0, 1, 1, S_FA);
    add(2, 0, 1, 0, 0, 0, 1, S_FA);
    add(1, 1, 0, 0, 0, 0, 1, S_CL);
    add(1, 0, 0, 0, 0, 0, 1, S_CL);
    add(1, 0, 1, 0, 0, 0, 1, S_PO);
    add(3, 0, 0, 0, 0, 0, 0, S_PO);
    add(3, 0, 0, 0, 0, 0, 0, S_OP);
    add(1, 1, 1, 0, 0, 0, 0, S_CL);  // reset mid-opening
    add(1, 0, 0, 0, 0, 0, 1, S_CL);
    add(1, 0, 1, 0, 0, 0, 1, S_PO);
    add(3, 0, 0, 0, 0, 0, 0, S_PO);
    add(1, 0, 0, 0, 0, 0, 0, S_OP);
    add(1, 0, 0, 0, 0, 1, 0, S_HO);
    add(1, 0, 0, 0, 0, 1, 1, S_FA);
    add(1, 0, 0, 0, 0, 1, 0, S_FA);
    add(1, 1, 0, 0, 0, 1, 1, S_CL);
    add(1, 0, 0, 0, 0, 0, 1, S_CL);
    step = 0;
    while (plan.size() != 0) begin
      drive_step();
      exp_v = sb.pop_front();
      got_v = {state, motor_open, motor_close, fault};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL test_limits_and_reset step %0d: {state,mo,mc,fault} observed %b required %b", step, got_v, exp_v);
      end
      step++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed state=%0d required test completion", state);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    step       = 0;
    rst        = 1'b1;
    open_req   = 1'b0;
    close_req  = 1'b0;
    obstruct   = 1'b0;
    lim_open   = 1'b0;
    lim_closed = 1'b1;
    test_reset();
    test_open_cycle();
    test_hold_controls();
    test_reversal();
    test_travel_fault();
    test_limits_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
